// File: rtl/data_sram_resp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : data_sram_resp                                               |
// | Brief   : Word SRAM data responder with byte enables and wait states   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq
);

  localparam int         c_DEPTH = 1 << ADDR_W;
  localparam logic [2:0] c_WAIT  = 3'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [31:0]       r_pend_data;
  logic              r_pend_read;
  logic [31:0]       r_mem [c_DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_accept;
  logic              w_is_read;
  logic [31:0]       w_rd_word;
  logic              w_unused_addr;

  assign w_idx         = data_sram_addr[ADDR_W+1:2];
  assign w_accept      = (r_state == S_IDLE) && data_sram_en;
  assign w_is_read     = (data_sram_wen == 4'b0000);
  assign w_rd_word     = r_mem[w_idx];
  assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Array is never reset; stores commit on the accept edge regardless of wait states.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && !w_is_read) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 3'd0;
      r_pend_data     <= 32'd0;
      r_pend_read     <= 1'b0;
      data_sram_rdata <= 32'd0;
      resp_valid      <= 1'b0;
      stallreq        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (c_WAIT == 3'd0) begin
              if (w_is_read) begin
                data_sram_rdata <= w_rd_word;
                resp_valid      <= 1'b1;
              end
            end else begin
              r_state     <= S_WAIT;
              r_cnt       <= c_WAIT;
              stallreq    <= 1'b1;
              r_pend_read <= w_is_read;
              r_pend_data <= w_rd_word;
            end
          end
        end
        S_WAIT: begin
          // Requests are ignored here: upstream holds the already-accepted one.
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state     <= S_IDLE;
            stallreq    <= 1'b0;
            r_pend_read <= 1'b0;
            if (r_pend_read) begin
              data_sram_rdata <= r_pend_data;
              resp_valid      <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          stallreq <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_data_sram_resp                                            |
// | Brief   : Scoreboard bench for data_sram_resp, zero and three waits    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_data_sram_resp;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata3;
  logic        rv0, rv3, st0, st3;

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata0), .resp_valid(rv0), .stallreq(st0)
  );

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata3), .resp_valid(rv3), .stallreq(st3)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          known;
  } exp_t;

  // Reference model: slot 0 mirrors 0 wait states, slot 1 mirrors 3.
  int          kval [2];
  logic [31:0] mmem [2][1024];
  bit          known [2][1024];
  exp_t        q0[$];
  exp_t        q1[$];
  int          free_c [2];
  int          st_lo [2];
  int          st_hi [2];
  logic [31:0] last_rd [2];
  int          cyc;
  int          n_chk;
  int          n_pass;
  bit          started;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input int j,
                     input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s dut_k%0d cycle %0d: got %h expected %h",
                  name, kval[j], cyc, act, expv);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      free_c[j]  = 0;
      st_lo[j]   = 1;
      st_hi[j]   = 0;
      last_rd[j] = 32'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_cycle(input int c);
    exp_t e;
    int   w;
    w = int'(addr[11:2]);
    for (int j = 0; j < 2; j++) begin
      if (en && c >= free_c[j]) begin
        if (wen != 4'd0) begin
          for (int b = 0; b < 4; b++)
            if (wen[b]) mmem[j][w][8*b +: 8] = wdata[8*b +: 8];
          known[j][w] = known[j][w] || (wen == 4'hF);
        end else begin
          e.data  = mmem[j][w];
          e.due   = c + 1 + kval[j];
          e.known = known[j][w];
          if (j == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        free_c[j] = c + kval[j] + 1;
        st_lo[j]  = c + 1;
        st_hi[j]  = c + kval[j];
      end
    end
  endtask

  task automatic check_port(input int j, input logic [31:0] rd,
                            input logic rv, input logic st);
    exp_t e;
    bit   exp_st;
    int   qs;
    exp_st = (cyc >= st_lo[j]) && (cyc <= st_hi[j]);
    chk(st === exp_st, "stallreq", j, 32'(st), 32'(exp_st));
    qs = (j == 0) ? q0.size() : q1.size();
    if (rv === 1'b1) begin
      if (qs == 0) begin
        chk(1'b0, "unexpected_resp", j, rd, 32'd0);
      end else begin
        e = (j == 0) ? q0.pop_front() : q1.pop_front();
        chk(e.due == cyc, "resp_cycle", j, 32'(cyc), 32'(e.due));
        if (e.known) chk(rd === e.data, "rdata", j, rd, e.data);
        last_rd[j] = rd;
        if (e.known) last_rd[j] = e.data;
      end
    end else begin
      chk(rv === 1'b0, "resp_valid_low", j, 32'(rv), 32'd0);
      chk(rd === last_rd[j], "rdata_hold", j, rd, last_rd[j]);
      if (qs != 0) begin
        e = (j == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          chk(1'b0, "missing_resp", j, 32'(cyc), 32'(e.due));
          if (j == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      check_port(0, rdata0, rv0, st0);
      check_port(1, rdata3, rv3, st3);
    end
  end

  task automatic step(input bit e, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] d);
    en = e; wen = we; addr = a; wdata = d;
    model_cycle(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(rdata0 === 32'd0 && rv0 === 1'b0 && st0 === 1'b0, name, 0,
        rdata0 ^ 32'(rv0) ^ 32'(st0), 32'd0);
    chk(rdata3 === 32'd0 && rv3 === 1'b0 && st3 === 1'b0, name, 1,
        rdata3 ^ 32'(rv3) ^ 32'(st3), 32'd0);
  endtask

  task automatic mid_reset();
    en = 1'b0; wen = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    kval[0] = 0;
    kval[1] = 3;
    for (int j = 0; j < 2; j++)
      for (int w = 0; w < 1024; w++) begin
        mmem[j][w]  = 32'd0;
        known[j][w] = 1'b0;
      end
    n_chk = 0; n_pass = 0; cyc = 0; started = 1'b0;
    model_reset();
    rst = 1'b0; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset_state");
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;

    // Fill the word window used by random traffic so every read is defined.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'hF, 32'(i) << 2, $urandom);
      idle(3);
    end

    // Zero-wait store/load and byte enables.
    step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF); idle(3);
    step(1'b1, 4'h0, 32'h10, 32'd0);        idle(4);
    chk(rdata0 === 32'hDEADBEEF, "store_load", 0, rdata0, 32'hDEADBEEF);
    chk(rdata3 === 32'hDEADBEEF, "store_load", 1, rdata3, 32'hDEADBEEF);
    step(1'b1, 4'b0101, 32'h10, 32'h11223344); idle(3);
    step(1'b1, 4'h0, 32'h10, 32'd0);           idle(4);
    chk(rdata0 === 32'hDE22BE44, "byte_en", 0, rdata0, 32'hDE22BE44);
    chk(rdata3 === 32'hDE22BE44, "byte_en", 1, rdata3, 32'hDE22BE44);

    // Back-to-back store then load of the same word.
    step(1'b1, 4'hF, 32'h14, 32'h0BADF00D);
    step(1'b1, 4'h0, 32'h14, 32'd0);
    idle(4);
    chk(rdata0 === 32'h0BADF00D, "store_to_load", 0, rdata0, 32'h0BADF00D);

    // Request held through the wait window, then a fresh load right after.
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 32'h10, 32'd0);
    step(1'b1, 4'h0, 32'h14, 32'd0);
    idle(5);

    // Aliasing through ignored address bits.
    step(1'b1, 4'hF, 32'h0000_0010, 32'hCAFEF00D); idle(3);
    step(1'b1, 4'h0, 32'h0000_1013, 32'd0);        idle(4);
    chk(rdata0 === 32'hCAFEF00D, "alias", 0, rdata0, 32'hCAFEF00D);
    chk(rdata3 === 32'hCAFEF00D, "alias", 1, rdata3, 32'hCAFEF00D);

    // Reset while the three-wait instance is stalled on a committed store.
    step(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5);
    idle(1);
    mid_reset();
    step(1'b1, 4'h0, 32'h20, 32'd0); idle(4);
    chk(rdata0 === 32'hA5A5A5A5, "write_survives_reset", 0, rdata0, 32'hA5A5A5A5);
    chk(rdata3 === 32'hA5A5A5A5, "write_survives_reset", 1, rdata3, 32'hA5A5A5A5);

    // Read data holds across later writes and idle cycles.
    step(1'b1, 4'hF, 32'h08, 32'h00000001); idle(3);
    step(1'b1, 4'h0, 32'h08, 32'd0);        idle(3);
    step(1'b1, 4'hF, 32'h0C, 32'h12345678); idle(3);
    step(1'b1, 4'h3, 32'h18, 32'hFFFFFFFF); idle(5);
    chk(rdata0 === 32'h1 && rv0 === 1'b0, "rdata_hold_direct", 0, rdata0, 32'h1);
    chk(rdata3 === 32'h1 && rv3 === 1'b0, "rdata_hold_direct", 1, rdata3, 32'h1);

    // Random traffic over 16 words with random ignored address bits.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  we;
      a  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 3) != 0, we, a, $urandom);
    end

    idle(10);
    chk(q0.size() == 0, "drain", 0, 32'(q0.size()), 32'd0);
    chk(q1.size() == 0, "drain", 1, 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
